// File: rtl/cache_tag_pkg.sv
// Shared types and pseudo-LRU helpers for the 4-way cache tag controller.
// Tree PLRU bits are {b2, b1, b0}: b0 picks the way pair, b1/b2 pick within the low/high pair.
package cache_tag_pkg;
  localparam int NUM_WAYS   = 4;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 37;
  localparam int VALID_BIT  = DATA_W_DEF - 1;

  typedef enum logic [2:0] {IDLE, READ, COMPARE, FILL, DONE} state_t;
  typedef logic [2:0] plru_t;

  function automatic logic [1:0] plru_victim(input plru_t bits);
    logic [1:0] v;
    if (!bits[0]) v = {1'b0, bits[1]};
    else          v = {1'b1, bits[2]};
    return v;
  endfunction

  function automatic plru_t plru_update(input plru_t bits, input logic [1:0] way);
    plru_t r;
    r    = bits;
    r[0] = ~way[1];
    if (!way[1]) r[1] = ~way[0];
    else         r[2] = ~way[0];
    return r;
  endfunction

  function automatic logic [1:0] lowest_way(input logic [NUM_WAYS-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (v[w]) r = 2'(w);
    end
    return r;
  endfunction
endpackage

// File: rtl/cache_tag_controller_if.sv
// Request/response bus plus tag-store port between cache pipeline, controller and ConjuntoTags.
interface cache_tag_if
  import cache_tag_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 37
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_index;
  logic [DATA_W-2:0]     req_tag;
  logic                  req_alloc;

  logic                  resp_valid;
  logic                  resp_hit;
  logic [1:0]            resp_way;
  logic                  resp_evict;
  logic [DATA_W-2:0]     resp_evict_tag;

  logic [NUM_WAYS-1:0]   ts_write_enable;
  logic                  ts_read_enable;
  logic [ADDR_W-1:0]     ts_adress;
  logic [DATA_W-1:0]     ts_data_in;
  logic [DATA_W-1:0]     ts_data_out1;
  logic [DATA_W-1:0]     ts_data_out2;
  logic [DATA_W-1:0]     ts_data_out3;
  logic [DATA_W-1:0]     ts_data_out4;

  modport slave (
    input  req_valid, req_index, req_tag, req_alloc,
    input  ts_data_out1, ts_data_out2, ts_data_out3, ts_data_out4,
    output req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
    output ts_write_enable, ts_read_enable, ts_adress, ts_data_in
  );

  modport master (
    output req_valid, req_index, req_tag, req_alloc,
    output ts_data_out1, ts_data_out2, ts_data_out3, ts_data_out4,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
    input  ts_write_enable, ts_read_enable, ts_adress, ts_data_in
  );
endinterface

// File: rtl/tag_plru_array.sv
// Per-set tree pseudo-LRU state: combinational read, one access-update write per cycle.
module tag_plru_array
  import cache_tag_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic [ADDR_W-1:0] rd_index,
  output plru_t             rd_bits,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [1:0]        wr_way
);
  localparam int SETS = 1 << ADDR_W;

  plru_t bits_q [SETS];
  plru_t wr_bits_d;

  assign rd_bits = bits_q[rd_index];

  always_comb begin
    wr_bits_d = plru_update(bits_q[wr_index], wr_way);
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      for (int i = 0; i < SETS; i++) bits_q[i] <= '0;
    end else if (we) begin
      bits_q[wr_index] <= wr_bits_d;
    end
  end
endmodule

// File: rtl/cache_tag_controller.sv
// Lookup/allocate controller for the 4-way tag store: read set, compare, optionally fill a victim.
// Invalid ways are filled first; only a full set consults the tree PLRU.
module cache_tag_controller
  import cache_tag_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic       clk,
  input  logic       gen_reset,
  cache_tag_if.slave bus
);
  localparam int TAG_W = DATA_W - 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              alloc_q, alloc_d;
  logic              resp_hit_q, resp_hit_d;
  logic [1:0]        resp_way_q, resp_way_d;
  logic              resp_evict_q, resp_evict_d;
  logic [TAG_W-1:0]  resp_evict_tag_q, resp_evict_tag_d;

  logic [DATA_W-1:0]   way_data [NUM_WAYS];
  logic [NUM_WAYS-1:0] hit_vec;
  logic [NUM_WAYS-1:0] invalid_vec;
  logic [1:0]          hit_way;
  logic [1:0]          victim_way;
  plru_t               plru_bits;
  logic                plru_we;
  logic [1:0]          plru_way;

  assign way_data[0] = bus.ts_data_out1;
  assign way_data[1] = bus.ts_data_out2;
  assign way_data[2] = bus.ts_data_out3;
  assign way_data[3] = bus.ts_data_out4;

  tag_plru_array #(.ADDR_W(ADDR_W)) u_plru (
    .clk      (clk),
    .gen_reset(gen_reset),
    .rd_index (idx_q),
    .rd_bits  (plru_bits),
    .we       (plru_we),
    .wr_index (idx_q),
    .wr_way   (plru_way)
  );

  always_comb begin
    hit_vec     = '0;
    invalid_vec = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w]     = way_data[w][TAG_W] && (way_data[w][TAG_W-1:0] == tag_q);
      invalid_vec[w] = ~way_data[w][TAG_W];
    end
    hit_way    = lowest_way(hit_vec);
    victim_way = (|invalid_vec) ? lowest_way(invalid_vec) : plru_victim(plru_bits);
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      idx_q            <= '0;
      tag_q            <= '0;
      alloc_q          <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_evict_q     <= 1'b0;
      resp_evict_tag_q <= '0;
    end else begin
      idx_q            <= idx_d;
      tag_q            <= tag_d;
      alloc_q          <= alloc_d;
      resp_hit_q       <= resp_hit_d;
      resp_way_q       <= resp_way_d;
      resp_evict_q     <= resp_evict_d;
      resp_evict_tag_q <= resp_evict_tag_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    tag_d            = tag_q;
    alloc_d          = alloc_q;
    resp_hit_d       = resp_hit_q;
    resp_way_d       = resp_way_q;
    resp_evict_d     = resp_evict_q;
    resp_evict_tag_d = resp_evict_tag_q;
    plru_we          = 1'b0;
    plru_way         = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          idx_d   = bus.req_index;
          tag_d   = bus.req_tag;
          alloc_d = bus.req_alloc;
          state_d = READ;
        end
      end
      READ: state_d = COMPARE;
      COMPARE: begin
        resp_hit_d       = 1'b0;
        resp_way_d       = '0;
        resp_evict_d     = 1'b0;
        resp_evict_tag_d = '0;
        state_d          = DONE;
        if (|hit_vec) begin
          resp_hit_d = 1'b1;
          resp_way_d = hit_way;
          plru_we    = 1'b1;
          plru_way   = hit_way;
        end else if (alloc_q) begin
          // resp_way doubles as the victim register for the following FILL cycle
          resp_way_d   = victim_way;
          resp_evict_d = way_data[victim_way][TAG_W];
          if (way_data[victim_way][TAG_W]) resp_evict_tag_d = way_data[victim_way][TAG_W-1:0];
          state_d      = FILL;
        end
      end
      FILL: begin
        plru_we  = 1'b1;
        plru_way = resp_way_q;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready       = (state_q == IDLE);
    bus.resp_valid      = (state_q == DONE);
    bus.ts_read_enable  = (state_q == READ);
    bus.ts_write_enable = '0;
    bus.ts_adress       = '0;
    bus.ts_data_in      = '0;
    if (state_q inside {READ, COMPARE, FILL}) bus.ts_adress = idx_q;
    if (state_q == FILL) begin
      bus.ts_write_enable[resp_way_q] = 1'b1;
      bus.ts_data_in                  = {1'b1, tag_q};
    end
  end

  assign bus.resp_hit       = resp_hit_q;
  assign bus.resp_way       = resp_way_q;
  assign bus.resp_evict     = resp_evict_q;
  assign bus.resp_evict_tag = resp_evict_tag_q;
endmodule

// File: tb/tb_cache_tag_controller.sv
// Self-checking bench for cache_tag_controller: behavioural tag store plus a reference cache model
// that tracks PLRU as "most recently used pair / way within each pair".
module tb_cache_tag_controller;
  localparam int AW = 10;
  localparam int DW = 37;
  localparam int TW = DW - 1;

  logic clk = 1'b0;
  logic gen_reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  cache_tag_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_tag_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .gen_reset(gen_reset),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // Tag store environment: registered read, per-way write.
  logic [DW-1:0] store [1024][4] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ts_read_enable) begin
      bus.ts_data_out1 <= store[bus.ts_adress][0];
      bus.ts_data_out2 <= store[bus.ts_adress][1];
      bus.ts_data_out3 <= store[bus.ts_adress][2];
      bus.ts_data_out4 <= store[bus.ts_adress][3];
    end
    for (int w = 0; w < 4; w++)
      if (bus.ts_write_enable[w]) store[bus.ts_adress][w] <= bus.ts_data_in;
  end

  // Reference model
  bit            ref_valid  [1024][4];
  logic [TW-1:0] ref_tag    [1024][4] = '{default: '0};
  bit            ref_pair_hi[1024];
  bit            ref_lo_mru [1024];
  bit            ref_hi_mru [1024];

  typedef struct {
    bit            hit;
    bit [1:0]      way;
    bit            evict;
    logic [TW-1:0] etag;
    int            lat;
    bit [3:0]      we;
  } exp_t;

  typedef struct {
    int            lat;
    logic          hit;
    logic [1:0]    way;
    logic          evict;
    logic [TW-1:0] etag;
    int            wr_cnt;
    int            wr_cycle;
    logic [3:0]    we;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
    bit            conflict;
    bit            pulse_ok;
    logic          ready_after;
  } obs_t;

  function automatic void ref_reset_plru();
    for (int s = 0; s < 1024; s++) begin
      ref_pair_hi[s] = 1'b1;
      ref_lo_mru[s]  = 1'b1;
      ref_hi_mru[s]  = 1'b1;
    end
  endfunction

  function automatic void ref_touch(int s, int w);
    ref_pair_hi[s] = (w >= 2);
    if (w < 2) ref_lo_mru[s] = (w == 1);
    else       ref_hi_mru[s] = (w == 3);
  endfunction

  function automatic int ref_victim(int s);
    if (ref_pair_hi[s]) return ref_lo_mru[s] ? 0 : 1;
    return ref_hi_mru[s] ? 2 : 3;
  endfunction

  task automatic ref_access(input logic [AW-1:0] s, input logic [TW-1:0] t, input bit a, output exp_t e);
    int hw, v;
    hw = -1; v = -1;
    e.hit = 0; e.way = 0; e.evict = 0; e.etag = '0; e.lat = 3; e.we = 4'b0;
    for (int w = 0; w < 4; w++)
      if (hw < 0 && ref_valid[s][w] && ref_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      e.hit = 1; e.way = 2'(hw); ref_touch(int'(s), hw);
    end else if (a) begin
      for (int w = 0; w < 4; w++) if (v < 0 && !ref_valid[s][w]) v = w;
      if (v < 0) v = ref_victim(int'(s));
      e.way = 2'(v); e.evict = ref_valid[s][v]; e.etag = ref_tag[s][v];
      e.lat = 4; e.we = 4'(1 << v);
      ref_valid[s][v] = 1'b1; ref_tag[s][v] = t; ref_touch(int'(s), v);
    end
  endtask

  // Issue one request and record what the DUT does until the response pulse ends.
  task automatic run_req(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input bit alloc, output obs_t o);
    int n;
    o.lat = -1; o.hit = 0; o.way = 0; o.evict = 0; o.etag = '0; o.wr_cnt = 0; o.wr_cycle = -1;
    o.we = 0; o.wdata = '0; o.waddr = '0; o.conflict = 0; o.pulse_ok = 0; o.ready_after = 0;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_index = idx; bus.req_tag = tag; bus.req_alloc = alloc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_index = AW'($urandom); bus.req_tag = TW'($urandom); bus.req_alloc = 1'($urandom);
      if (bus.ts_write_enable != 4'b0) begin
        o.wr_cnt++; o.wr_cycle = k; o.we = bus.ts_write_enable;
        o.wdata = bus.ts_data_in; o.waddr = bus.ts_adress;
        if (bus.ts_read_enable) o.conflict = 1;
      end
      if (bus.resp_valid) begin
        o.lat = k; o.hit = bus.resp_hit; o.way = bus.resp_way;
        o.evict = bus.resp_evict; o.etag = bus.resp_evict_tag;
        @(negedge clk);
        o.pulse_ok = !bus.resp_valid;
        o.ready_after = bus.req_ready;
        break;
      end
    end
  endtask

  task automatic test_reset;
    gen_reset = 1'b1;
    bus.req_valid = 0; bus.req_index = '0; bus.req_tag = '0; bus.req_alloc = 0;
    ref_reset_plru();
    repeat (2) @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    tests_run++; if ({bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_evict} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_resp got %b want 00000", {bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_evict}); end
    tests_run++; if (bus.resp_evict_tag !== '0) begin tests_failed++; $display("FAIL reset_evict_tag got %h want 0", bus.resp_evict_tag); end
    tests_run++; if ({bus.ts_write_enable, bus.ts_read_enable} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ts_en got %b want 00000", {bus.ts_write_enable, bus.ts_read_enable}); end
    tests_run++; if (bus.ts_adress !== '0 || bus.ts_data_in !== '0) begin
      tests_failed++; $display("FAIL reset_ts_bus got adr %h data %h want 0", bus.ts_adress, bus.ts_data_in); end
    gen_reset = 1'b0;
  endtask

  task automatic test_alloc_empty;
    obs_t o; exp_t e;
    ref_access(10'd1, 36'd15, 1'b1, e);
    run_req(10'd1, 36'd15, 1'b1, o);
    tests_run++; if (o.lat != 4) begin tests_failed++; $display("FAIL alloc_latency got %0d want 4", o.lat); end
    tests_run++; if ({o.hit, o.way, o.evict} !== 4'b0) begin tests_failed++; $display("FAIL alloc_resp got %b want 0000", {o.hit, o.way, o.evict}); end
    tests_run++; if (o.wr_cnt != 1 || o.wr_cycle != 3) begin
      tests_failed++; $display("FAIL alloc_write_timing got cnt %0d cycle %0d want 1/3", o.wr_cnt, o.wr_cycle); end
    tests_run++; if (o.we !== 4'b0001 || o.we !== e.we) begin tests_failed++; $display("FAIL alloc_we got %b want 0001", o.we); end
    tests_run++; if (o.wdata !== {1'b1, 36'd15} || o.waddr !== 10'd1) begin
      tests_failed++; $display("FAIL alloc_wdata got %h@%0d want %h@1", o.wdata, o.waddr, {1'b1, 36'd15}); end
    tests_run++; if (!o.pulse_ok || o.ready_after !== 1'b1) begin
      tests_failed++; $display("FAIL alloc_pulse got pulse_ok %0d ready %b want 1/1", o.pulse_ok, o.ready_after); end
  endtask

  task automatic test_hit;
    obs_t o; exp_t e;
    ref_access(10'd1, 36'd15, 1'b0, e);
    run_req(10'd1, 36'd15, 1'b0, o);
    tests_run++; if (o.lat != 3) begin tests_failed++; $display("FAIL hit_latency got %0d want 3", o.lat); end
    tests_run++; if (o.hit !== 1'b1 || o.way !== 2'd0 || o.evict !== 1'b0) begin
      tests_failed++; $display("FAIL hit_resp got hit %b way %0d evict %b want 1/0/0", o.hit, o.way, o.evict); end
    tests_run++; if (o.wr_cnt != 0) begin tests_failed++; $display("FAIL hit_no_write got %0d writes want 0", o.wr_cnt); end
  endtask

  task automatic test_plru_evict;
    obs_t o; exp_t e;
    logic [TW-1:0] tags [4];
    tags[0] = 36'd15; tags[1] = 36'd31; tags[2] = 36'd47; tags[3] = 36'd63;
    for (int w = 0; w < 4; w++) begin
      ref_access(10'd1, tags[w], 1'b1, e);
      run_req(10'd1, tags[w], 1'b1, o);
      tests_run++; if (o.way !== 2'(w) || o.lat != e.lat) begin
        tests_failed++; $display("FAIL fill_way%0d got way %0d lat %0d want %0d/%0d", w, o.way, o.lat, w, e.lat); end
    end
    ref_access(10'd1, 36'd15, 1'b0, e);
    run_req(10'd1, 36'd15, 1'b0, o);
    tests_run++; if (o.hit !== 1'b1 || o.way !== 2'd0) begin tests_failed++; $display("FAIL plru_touch got hit %b way %0d want 1/0", o.hit, o.way); end
    ref_access(10'd1, 36'd79, 1'b1, e);
    run_req(10'd1, 36'd79, 1'b1, o);
    tests_run++; if (o.way !== 2'd2 || o.hit !== 1'b0) begin tests_failed++; $display("FAIL plru_victim got way %0d hit %b want 2/0", o.way, o.hit); end
    tests_run++; if (o.evict !== 1'b1 || o.etag !== 36'd47) begin
      tests_failed++; $display("FAIL plru_evict got evict %b tag %0d want 1/47", o.evict, o.etag); end
    tests_run++; if (o.we !== 4'b0100 || o.wdata !== {1'b1, 36'd79}) begin
      tests_failed++; $display("FAIL plru_write got we %b data %h want 0100/%h", o.we, o.wdata, {1'b1, 36'd79}); end
  endtask

  task automatic test_miss_noalloc;
    obs_t o; exp_t e;
    for (int w = 0; w < 4; w++) begin
      ref_access(10'd2, TW'(201 + w), 1'b1, e);
      run_req(10'd2, TW'(201 + w), 1'b1, o);
    end
    ref_access(10'd2, 36'd99, 1'b0, e);
    run_req(10'd2, 36'd99, 1'b0, o);
    tests_run++; if (o.lat != 3 || o.hit !== 1'b0 || o.way !== 2'd0) begin
      tests_failed++; $display("FAIL miss_resp got lat %0d hit %b way %0d want 3/0/0", o.lat, o.hit, o.way); end
    tests_run++; if (o.wr_cnt != 0) begin tests_failed++; $display("FAIL miss_no_write got %0d writes want 0", o.wr_cnt); end
    ref_access(10'd2, 36'd205, 1'b1, e);
    run_req(10'd2, 36'd205, 1'b1, o);
    tests_run++; if (o.way !== 2'd0 || o.way !== e.way || o.evict !== 1'b1 || o.etag !== 36'd201) begin
      tests_failed++; $display("FAIL miss_plru_kept got way %0d evict %b tag %0d want 0/1/201", o.way, o.evict, o.etag); end
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    logic [AW-1:0] s; logic [TW-1:0] t; bit a;
    for (int i = 0; i < 40; i++) begin
      s = AW'(8 + $urandom_range(0, 3));
      t = TW'($urandom_range(1, 6));
      a = 1'($urandom_range(0, 1));
      ref_access(s, t, a, e);
      run_req(s, t, a, o);
      tests_run++; if (o.lat != e.lat || o.hit !== e.hit || o.way !== e.way || o.evict !== e.evict) begin
        tests_failed++;
        $display("FAIL rand%0d_resp got lat %0d hit %b way %0d ev %b want %0d/%b/%0d/%b", i, o.lat, o.hit, o.way, o.evict, e.lat, e.hit, e.way, e.evict);
      end
      tests_run++; if ((e.evict && o.etag !== e.etag) || o.we !== e.we || o.conflict) begin
        tests_failed++; $display("FAIL rand%0d_write got tag %0d we %b rw %0d want %0d/%b/0", i, o.etag, o.we, o.conflict, e.etag, e.we);
      end
      if (e.we != 0) begin
        tests_run++; if (o.wdata !== {1'b1, t} || o.waddr !== s || o.wr_cycle != 3) begin
          tests_failed++; $display("FAIL rand%0d_wdata got %h@%0d c%0d want %h@%0d c3", i, o.wdata, o.waddr, o.wr_cycle, {1'b1, t}, s);
        end
      end
    end
  endtask

  task automatic test_reset_fill;
    obs_t o; exp_t e;
    int k; bit saw_resp;
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_index = 10'd20; bus.req_tag = 36'd5; bus.req_alloc = 1'b1;
    k = 0;
    while (k < 8) begin
      @(negedge clk); k++;
      bus.req_valid = 1'b0;
      if (bus.ts_write_enable != 4'b0) break;
    end
    tests_run++; if (k != 3 || bus.ts_write_enable !== 4'b0001) begin
      tests_failed++; $display("FAIL rstfill_reach got cycle %0d we %b want 3/0001", k, bus.ts_write_enable); end
    #1 gen_reset = 1'b1;
    #1;
    tests_run++; if (bus.ts_write_enable !== 4'b0) begin tests_failed++; $display("FAIL rstfill_we_async got %b want 0000", bus.ts_write_enable); end
    ref_reset_plru();
    saw_resp = bus.resp_valid;
    repeat (2) begin @(negedge clk); saw_resp |= bus.resp_valid; end
    gen_reset = 1'b0;
    repeat (3) begin @(negedge clk); saw_resp |= bus.resp_valid; end
    tests_run++; if (saw_resp) begin tests_failed++; $display("FAIL rstfill_no_resp got resp_valid 1 want 0"); end
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rstfill_ready got %b want 1", bus.req_ready); end
    ref_access(10'd20, 36'd5, 1'b0, e);
    run_req(10'd20, 36'd5, 1'b0, o);
    tests_run++; if (o.hit !== e.hit || o.hit !== 1'b0 || o.lat != 3) begin
      tests_failed++; $display("FAIL rstfill_no_write got hit %b lat %0d want 0/3", o.hit, o.lat); end
  endtask

  task automatic test_back_to_back;
    exp_t q[$]; exp_t e, f;
    int cyc, last, nresp; bit prev;
    cyc = 0; last = -1; nresp = 0; prev = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_index = AW'(30 + $urandom_range(0, 1)); bus.req_tag = TW'($urandom_range(1, 4)); bus.req_alloc = 1'($urandom);
    while (nresp < 12 && cyc < 200) begin
      if (bus.req_ready && bus.req_valid) begin
        ref_access(bus.req_index, bus.req_tag, bus.req_alloc, e);
        q.push_back(e);
      end
      @(negedge clk); cyc++;
      bus.req_index = AW'(30 + $urandom_range(0, 1)); bus.req_tag = TW'($urandom_range(1, 4)); bus.req_alloc = 1'($urandom);
      if (bus.resp_valid) begin
        tests_run++; if (prev) begin tests_failed++; $display("FAIL b2b_width resp_valid high %0d cycles want 1", 2); end
        if (q.size() == 0) begin
          tests_run++; tests_failed++; $display("FAIL b2b_unexpected_resp got resp with 0 pending want none");
        end else begin
          f = q.pop_front();
          tests_run++; if (bus.resp_hit !== f.hit || bus.resp_way !== f.way || bus.resp_evict !== f.evict) begin
            tests_failed++; $display("FAIL b2b_resp%0d got %b/%0d/%b want %b/%0d/%b", nresp, bus.resp_hit, bus.resp_way, bus.resp_evict, f.hit, f.way, f.evict);
          end
        end
        if (last >= 0) begin
          tests_run++; if (cyc - last != 4 && cyc - last != 5) begin
            tests_failed++; $display("FAIL b2b_spacing got %0d cycles want 4 or 5", cyc - last); end
        end
        last = cyc; nresp++;
      end
      prev = bus.resp_valid;
    end
    bus.req_valid = 1'b0;
    tests_run++; if (nresp != 12) begin tests_failed++; $display("FAIL b2b_count got %0d responses want 12", nresp); end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_empty();
    test_hit();
    test_plru_evict();
    test_miss_noalloc();
    test_random();
    test_reset_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
